// File: rtl/precision_config_ctrl_pkg.sv
// rtl/precision_config_ctrl_pkg.sv - width encodings, legality check and FSM states for precision config
package precision_config_ctrl_pkg;

    localparam logic [3:0] W1 = 4'b0001;
    localparam logic [3:0] W2 = 4'b0010;
    localparam logic [3:0] W4 = 4'b0100;
    localparam logic [3:0] W8 = 4'b1000;
    localparam logic [3:0] DEFAULT_WIDTH = W8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        APPLY = 2'd3
    } state_e;

    function automatic logic is_legal_width(input logic [3:0] w);
        return (w == W1) || (w == W2) || (w == W4) || (w == W8);
    endfunction

endpackage

// File: rtl/precision_config_ctrl.sv
// rtl/precision_config_ctrl.sv - accepts per-layer precision commands and reconfigures the fusion array safely
module precision_config_ctrl
    import precision_config_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int LAYER_ID_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [3:0]            cfg_in_width,
    input  logic [3:0]            cfg_weight_width,
    input  logic [LAYER_ID_W-1:0] cfg_layer_id,
    input  logic                  array_busy,
    output logic                  array_stall,
    output logic [3:0]            in_width,
    output logic [3:0]            weight_width,
    output logic [LAYER_ID_W-1:0] active_layer_id,
    output logic                  cfg_done,
    output logic                  cfg_err
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            in_width_q, weight_width_q;
    logic [LAYER_ID_W-1:0] layer_id_q;
    logic [3:0]            sh_in_q, sh_wt_q;
    logic [LAYER_ID_W-1:0] sh_id_q;
    logic                  done_q, err_q;

    logic accept, cmd_legal, cmd_same;

    assign accept    = cfg_valid && (state_q == IDLE);
    assign cmd_legal = is_legal_width(cfg_in_width) && is_legal_width(cfg_weight_width);
    assign cmd_same  = (cfg_in_width == in_width_q) && (cfg_weight_width == weight_width_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  if (accept && cmd_legal && !cmd_same) state_d = DRAIN;
            DRAIN: if (!array_busy) begin
                       state_d = FLUSH;
                       cnt_d   = CNT_LOAD;
                   end
            FLUSH: if (cnt_q == '0) state_d = APPLY;
                   else             cnt_d   = cnt_q - CNT_W'(1);
            APPLY: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready   = (state_q == IDLE);
        array_stall = (state_q != IDLE);
    end

    // Fast path (same widths) and reject never touch the shadow copy or stall the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_width_q     <= DEFAULT_WIDTH;
            weight_width_q <= DEFAULT_WIDTH;
            layer_id_q     <= '0;
            sh_in_q        <= DEFAULT_WIDTH;
            sh_wt_q        <= DEFAULT_WIDTH;
            sh_id_q        <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (accept) begin
                if (!cmd_legal) begin
                    err_q <= 1'b1;
                end else if (cmd_same) begin
                    layer_id_q <= cfg_layer_id;
                    done_q     <= 1'b1;
                end else begin
                    sh_in_q <= cfg_in_width;
                    sh_wt_q <= cfg_weight_width;
                    sh_id_q <= cfg_layer_id;
                end
            end
            if (state_q == APPLY) begin
                in_width_q     <= sh_in_q;
                weight_width_q <= sh_wt_q;
                layer_id_q     <= sh_id_q;
                done_q         <= 1'b1;
            end
        end
    end

    assign in_width        = in_width_q;
    assign weight_width    = weight_width_q;
    assign active_layer_id = layer_id_q;
    assign cfg_done        = done_q;
    assign cfg_err         = err_q;

endmodule
